// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: binary (optionally two's complement) to six packed BCD digits.
// The magnitude is clamped to 999999, so 20 shift iterations always suffice regardless of BIN_W.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 24,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             valid,
    output logic [23:0]      bcd,
    output logic             neg,
    output logic             ovf
);

    localparam int DIG_W = 24;
    localparam int VAL_W = 20;
    localparam int SR_W  = DIG_W + VAL_W;

    localparam logic [BIN_W:0]   MAX_MAG = (BIN_W+1)'(999999);
    localparam logic [VAL_W-1:0] MAX_VAL = 20'd999999;
    localparam logic [4:0]       ITERS   = 5'd20;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_next;
    logic [4:0]        cnt;
    logic              neg_cap;
    logic              ovf_cap;

    logic              in_neg;
    logic [BIN_W:0]    in_mag;
    logic              in_ovf;
    logic [VAL_W-1:0]  in_val;

    // One extra bit keeps the magnitude of the most negative input representable.
    always_comb begin
        in_neg = SIGNED && bin[BIN_W-1];
        in_mag = in_neg ? -{1'b1, bin} : {1'b0, bin};
        in_ovf = in_mag > MAX_MAG;
        in_val = in_ovf ? MAX_VAL : in_mag[VAL_W-1:0];
    end

    // NOTE: assigning a full default before the conditional updates keeps this purely combinational (no latch).
    always_comb begin
        logic [SR_W-1:0] adj;
        adj = sr;
        for (int i = 0; i < 6; i++) begin
            if (sr[VAL_W + 4*i +: 4] >= 4'd5) begin
                adj[VAL_W + 4*i +: 4] = sr[VAL_W + 4*i +: 4] + 4'd3;
            end
        end
        sr_next = {adj[SR_W-2:0], 1'b0};
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            neg_cap <= 1'b0;
            ovf_cap <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            bcd     <= '0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr      <= {{DIG_W{1'b0}}, in_val};
                        cnt     <= ITERS;
                        neg_cap <= in_neg;
                        ovf_cap <= in_ovf;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= sr_next;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd   <= sr[SR_W-1:VAL_W];
                    neg   <= neg_cap;
                    ovf   <= ovf_cap;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
